// File: rtl/qed_dup_sequencer_if.sv
// Sequencer <-> QED instruction queue bundle. The stats outputs exist only when
// QED_DUP_STATS_EN is defined.
interface qed_dup_sequencer_if;
  logic       qed_ena;
  logic       sync_req;
  logic       IF_stall;
  logic       vld_out;
  logic       exec_dup;
  logic [8:0] pending;
  logic       check_ready;
  logic       busy;
  logic       qed_err;
`ifdef QED_DUP_STATS_EN
  logic [15:0] win_cnt;
  logic [8:0]  max_pending;
`endif

  modport master (
    input  qed_ena, sync_req, IF_stall, vld_out,
    output exec_dup, pending, check_ready, busy, qed_err
`ifdef QED_DUP_STATS_EN
    , output win_cnt, max_pending
`endif
  );

  modport slave (
    output qed_ena, sync_req, IF_stall, vld_out,
    input  exec_dup, pending, check_ready, busy, qed_err
`ifdef QED_DUP_STATS_EN
    , input win_cnt, max_pending
`endif
  );
endinterface

// File: rtl/qed_dup_sequencer.sv
// QED mode sequencer: fills the queue in ORIG, replays it in DUP, pulses check_ready
// in CHECK. Optional window statistics under QED_DUP_STATS_EN.
module qed_dup_sequencer #(
  parameter int ICACHESIZE = 256,
  parameter int BURST      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  qed_dup_sequencer_if.master  bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ORIG  = 2'd1,
    DUP   = 2'd2,
    CHECK = 2'd3
  } state_e;

  localparam logic [8:0] BURST_LVL = 9'(BURST);
  localparam logic [8:0] FULL_LVL  = 9'(ICACHESIZE - 1);

  state_e     state_q, state_d;
  logic [8:0] pending_q, pending_d;
  logic       exec_dup_q, check_ready_q, busy_q, qed_err_q, err_d;
  logic       ins, del;

  assign ins = bus.vld_out & ~exec_dup_q;
  assign del = bus.vld_out & exec_dup_q;

  // Next state, next count and protocol-error detection
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    err_d     = qed_err_q;
    if (bus.vld_out && bus.IF_stall) begin
      err_d = 1'b1;
    end else begin
      err_d = err_d;
    end
    case (state_q)
      IDLE: begin
        if (bus.vld_out) err_d = 1'b1;
        else             err_d = err_d;
        if (bus.qed_ena) state_d = ORIG;
        else             state_d = IDLE;
      end
      ORIG: begin
        if (ins) pending_d = pending_q + 9'd1;
        else     pending_d = pending_q;
        // Limit insert wins over sync_req, which wins over enable drop
        if (ins && (pending_d == BURST_LVL || pending_d == FULL_LVL)) begin
          state_d = DUP;
        end else if (bus.sync_req) begin
          state_d = (pending_d != 9'd0) ? DUP : CHECK;
        end else if (!bus.qed_ena) begin
          state_d = (pending_d != 9'd0) ? DUP : IDLE;
        end else begin
          state_d = ORIG;
        end
      end
      DUP: begin
        if (del && pending_q == 9'd0) begin
          err_d = 1'b1;
        end else if (del) begin
          pending_d = pending_q - 9'd1;
          if (pending_q == 9'd1) state_d = CHECK;
          else                   state_d = DUP;
        end else begin
          state_d = DUP;
        end
      end
      CHECK: begin
        if (bus.vld_out) err_d = 1'b1;
        else             err_d = err_d;
        state_d = bus.qed_ena ? ORIG : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs, all decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pending_q     <= 9'd0;
      exec_dup_q    <= 1'b0;
      check_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      qed_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      exec_dup_q    <= (state_d == DUP);
      check_ready_q <= (state_d == CHECK);
      busy_q        <= (state_d != IDLE);
      qed_err_q     <= err_d;
    end
  end

  assign bus.exec_dup    = exec_dup_q;
  assign bus.pending     = pending_q;
  assign bus.check_ready = check_ready_q;
  assign bus.busy        = busy_q;
  assign bus.qed_err     = qed_err_q;

`ifdef QED_DUP_STATS_EN
  logic [15:0] win_cnt_q;
  logic [8:0]  max_pending_q;

  // Saturating window counter and peak occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q     <= 16'd0;
      max_pending_q <= 9'd0;
    end else begin
      if (check_ready_q && win_cnt_q != 16'hFFFF) win_cnt_q <= win_cnt_q + 16'd1;
      if (pending_d > max_pending_q)             max_pending_q <= pending_d;
    end
  end

  assign bus.win_cnt     = win_cnt_q;
  assign bus.max_pending = max_pending_q;
`endif
endmodule

// File: doc/qed_dup_sequencer.md
# qed_dup_sequencer

Mode sequencer for the QED instruction path. It drives `exec_dup` into the QED instruction queue and tracks queue occupancy from the queue's `vld_out` strobe. It alternates between original mode, which fills the queue, and duplicate mode, which replays and drains it. After each full replay it emits a one-cycle `check_ready` pulse so the consistency checker can compare original and duplicate register state.

## Interface
- `ICACHESIZE`, 256: queue depth; the queue holds at most ICACHESIZE-1 entries.
- `BURST`, 16: number of original instructions queued before a forced switch to duplicate mode; legal range 1..ICACHESIZE-1.
- `clk` in 1: single clock; all state updates on posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `qed_ena` in 1: QED enable; level-sensitive.
- `sync_req` in 1: request to close the current window early (e.g. before a store or branch resolves).
- `IF_stall` in 1: fetch stall; qualifies nothing here, because `vld_out` already includes it; used only for error checking.
- `vld_out` in 1: queue strobe. High with `exec_dup`=0 means one insert; high with `exec_dup`=1 means one delete.
- `exec_dup` out 1: registered mode to the queue; 1 selects replay.
- `pending` out 9: registered count of queued, not-yet-replayed instructions.
- `check_ready` out 1: registered one-cycle pulse marking the end of a matched original/duplicate window.
- `busy` out 1: high in any state other than IDLE.
- `qed_err` out 1: sticky protocol-error flag.

## Operation
- States: IDLE, ORIG, DUP, CHECK; state is held in a register.
- `exec_dup` is 1 only in DUP.
- Insert accepted (`ins`) = `vld_out` & ~`exec_dup`. Delete accepted (`del`) = `vld_out` & `exec_dup`.
- `pending` update: +1 on `ins` in ORIG; -1 on `del` in DUP; otherwise hold. It is 9 bits, never wraps, and saturates logically through the FSM.
- IDLE:
  - `qed_ena`=1 -> ORIG.
  - `sync_req` is ignored.
- ORIG:
  - `ins` with `pending`+1 == BURST or == ICACHESIZE-1 -> DUP.
  - Else `sync_req` with `pending`!=0 (after this cycle's update) -> DUP.
  - `sync_req` with `pending`==0 and no `ins` -> CHECK (empty window).
  - `qed_ena`=0 with `pending`!=0 -> DUP (drain before leaving).
  - `qed_ena`=0 with `pending`==0 -> IDLE.
  - Priority: limit/full > `sync_req` > `qed_ena` drop.
- DUP:
  - `del` with `pending`==1 -> CHECK.
  - `qed_ena` and `sync_req` are ignored; a window always drains fully.
- CHECK:
  - `check_ready`=1 for exactly this cycle.
  - Next state: ORIG if `qed_ena`=1, else IDLE.
- Errors (set `qed_err`, cleared only by reset):
  - `vld_out`=1 in IDLE or CHECK.
  - `vld_out`=1 while `IF_stall`=1.
  - `del` in DUP with `pending`==0.
  - On an error the FSM continues normally, and `pending` is not decremented below 0.

## Timing
- Reset values: state IDLE, `exec_dup` 0, `pending` 0, `check_ready` 0, `busy` 0, `qed_err` 0; all take effect immediately on `rst_n` low.
- Reset mid-window discards the count; the queue is reset by the same event.
- Insert reaching the limit at cycle t: `pending`=BURST and `exec_dup`=1 at t+1.
- Last delete at cycle t: `pending`=0 and `check_ready`=1 at t+1; ORIG (with `exec_dup`=0) at t+2.
- Minimum window period is BURST + BURST + 1 cycles with no stalls.
- Stalls (`vld_out` low) simply hold state and count; there is no timeout.
- `sync_req` and the limit insert in the same cycle: the limit insert is counted, then DUP.

## Configuration
- `QED_DUP_STATS_EN`:
  - Defined: adds output `win_cnt` [15:0], reset 0. It increments on every `check_ready` and saturates at 16'hFFFF. It also adds output `max_pending` [8:0], the highest `pending` seen since reset.
  - Undefined: neither port nor its logic exists; all other behaviour is identical.

## Test plan
- Reset, `qed_ena`=1, `vld_out`=1 every cycle with BURST=16: `exec_dup` rises on the cycle after the 16th insert with `pending`=16; after 16 deletes, `check_ready` pulses once and `pending`=0.
- 3 inserts, then `sync_req`=1: DUP next cycle with `pending`=3; after 3 deletes, `check_ready`=1 for one cycle, then ORIG.
- BURST=255, ICACHESIZE=256, continuous inserts: switch to DUP at `pending`=255; no insert is counted beyond that.
- `qed_ena` dropped at `pending`=5 in ORIG: DUP drains 5, CHECK, then IDLE with `busy`=0.
- `vld_out`=1 in IDLE, and separately `vld_out`=1 with `IF_stall`=1: `qed_err`=1 and stays high until `rst_n` pulses low.
- `rst_n` asserted low asynchronously in DUP at `pending`=7: `exec_dup`=0 and `pending`=0 immediately; with `QED_DUP_STATS_EN` defined, `win_cnt` reads 0.
